weight_loader: RTL and testbench



---
 rtl/wl_pkg.sv | 26 ++
 rtl/wl_if.sv | 25 ++
 rtl/wl_skid_fifo.sv | 44 ++++
 rtl/weight_loader.sv | 164 ++++++++++++++++
 tb/tb_weight_loader.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wl_pkg.sv
// wl_pkg: shared types and sizing for the weight loader.
// Holds the FSM state encoding, tile-shape limits and the tile word-count helper.
package wl_pkg;

  localparam int ROW_NUM = 32;                    // largest tile height
  localparam int MAX_WPR = 8;                     // largest words-per-row
  localparam int WORD_W  = 32;                    // weight word width
  localparam int ROW_W   = $clog2(ROW_NUM + 1);   // holds 0..ROW_NUM
  localparam int WPR_W   = $clog2(MAX_WPR + 1);   // holds 1..MAX_WPR
  localparam int CNT_W   = $clog2(ROW_NUM * MAX_WPR + 1); // holds 0..256

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    DONE
  } wl_state_e;

  // Number of words in a tile: rows times words-per-row.
  function automatic logic [CNT_W-1:0] tile_words(input logic [ROW_W-1:0] rows,
                                                  input logic [WPR_W-1:0] wpr);
    return CNT_W'(rows) * CNT_W'(wpr);
  endfunction

endpackage

// File: rtl/wl_if.sv
// wl_if: GLB read port plus the weight-word stream towards the weight buffer.
// master = loader side, slave = GLB / buffer side.
interface wl_if #(
  parameter int ADDR_W = 32
);
  import wl_pkg::*;

  logic              glb_re;
  logic [ADDR_W-1:0] glb_addr;
  logic [WORD_W-1:0] glb_rdata;
  logic              valid_w;
  logic              ready_w;
  logic [WORD_W-1:0] weight_in;

  modport master (
    output glb_re, glb_addr, valid_w, weight_in,
    input  glb_rdata, ready_w
  );

  modport slave (
    input  glb_re, glb_addr, valid_w, weight_in,
    output glb_rdata, ready_w
  );

endinterface

// File: rtl/wl_skid_fifo.sv
// wl_skid_fifo: 2-entry FIFO that catches GLB read data while the buffer stalls.
// Entry 0 is always the head, so dout comes straight from a register.
module wl_skid_fifo
  import wl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] mem_reg [2];
  logic [1:0]        count_reg;
  logic [1:0]        wr_idx;

  // A simultaneous pop shifts the queue down, so the write slot moves down too.
  assign wr_idx = count_reg - {1'b0, pop};

  // Shift-on-pop storage with an occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      count_reg  <= '0;
    end else begin
      if (push && wr_idx == 2'd0) begin
        mem_reg[0] <= din;
      end else if (pop) begin
        mem_reg[0] <= mem_reg[1];
      end
      if (push && wr_idx == 2'd1) begin
        mem_reg[1] <= din;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/weight_loader.sv
// weight_loader: fetches one weight tile from the GLB and streams it to the
// horizontal weight buffer over valid_w/ready_w in row-major order.
// Optional feature macro: WL_DW_EN enables depthwise (DW) mode; without it the
// DW_PW_sel input is ignored and every tile is treated as pointwise.
module weight_loader
  import wl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              DW_PW_sel,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ROW_W-1:0]  row_num,
  input  logic [4:0]        col_in,
  wl_if.master              bus,
  output logic [ROW_W-1:0]  row_en,
  output logic [4:0]        col_out,
  output logic              DW_PW_sel_out,
  output logic              change_weight_f,
  output logic              busy,
  output logic              done
);

  wl_state_e         state_reg;
  logic [ROW_W-1:0]  row_en_reg;
  logic [4:0]        col_out_reg;
  logic              change_weight_f_reg;
  logic              done_reg;
  logic              inflight_reg;
  logic [CNT_W-1:0]  total_reg;
  logic [CNT_W-1:0]  issue_cnt_reg;
  logic [CNT_W-1:0]  pop_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic [1:0]        fifo_count;
  logic [WORD_W-1:0] fifo_dout;
  logic              pop;
  logic              glb_re;
  logic [2:0]        credit_used;
  logic              last_issue;
  logic              last_pop;
  logic              start_mode;
  logic [WPR_W-1:0]  start_wpr;

`ifdef WL_DW_EN
  logic mode_reg;
  assign start_mode    = DW_PW_sel;
  assign DW_PW_sel_out = mode_reg;
`else
  assign start_mode    = DW_PW_sel | 1'b1;
  assign DW_PW_sel_out = 1'b1;
`endif

  // DW tiles carry one word per row; PW rows are col_in[4:2]+1 words long.
  assign start_wpr = start_mode ? (WPR_W'(col_in[4:2]) + WPR_W'(1)) : WPR_W'(1);

  assign pop        = bus.valid_w && bus.ready_w;
  assign last_issue = (issue_cnt_reg == total_reg - CNT_W'(1));
  assign last_pop   = (pop_cnt_reg == total_reg - CNT_W'(1));

  // Credit check: words held plus the one in flight, minus this cycle's pop,
  // must leave room in the FIFO for the read we are about to issue.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
    glb_re      = (state_reg == FETCH) && (credit_used < 3'd2);
  end

  wl_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_reg),
    .pop   (pop),
    .din   (bus.glb_rdata),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Tile FSM, address/word counters, in-flight tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= IDLE;
      row_en_reg          <= '0;
      col_out_reg         <= '0;
      change_weight_f_reg <= 1'b0;
      done_reg            <= 1'b0;
      inflight_reg        <= 1'b0;
      total_reg           <= '0;
      issue_cnt_reg       <= '0;
      pop_cnt_reg         <= '0;
      addr_reg            <= '0;
`ifdef WL_DW_EN
      mode_reg            <= 1'b0;
`endif
    end else begin
      change_weight_f_reg <= 1'b0;
      done_reg            <= 1'b0;
      inflight_reg        <= glb_re;
      if (glb_re) begin
        addr_reg      <= addr_reg + ADDR_W'(4);
        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
      end
      if (pop) begin
        pop_cnt_reg <= pop_cnt_reg + CNT_W'(1);
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            row_en_reg    <= row_num;
            col_out_reg   <= col_in;
`ifdef WL_DW_EN
            mode_reg      <= start_mode;
`endif
            total_reg     <= tile_words(row_num, start_wpr);
            addr_reg      <= base_addr;
            issue_cnt_reg <= '0;
            pop_cnt_reg   <= '0;
            if (row_num == '0) begin
              state_reg <= DONE;
            end else begin
              state_reg           <= CLEAR;
              change_weight_f_reg <= 1'b1;
            end
          end
        end
        CLEAR: state_reg <= FETCH;
        FETCH: begin
          if (glb_re && last_issue) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last_pop) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          // An empty tile arrives here without done set; it spends one more
          // cycle so its pulse lands two cycles after start.
          if (!done_reg) begin
            done_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.glb_re    = glb_re;
  assign bus.glb_addr  = addr_reg;
  assign bus.valid_w   = (fifo_count != 2'd0);
  assign bus.weight_in = fifo_dout;

  assign row_en          = row_en_reg;
  assign col_out         = col_out_reg;
  assign change_weight_f = change_weight_f_reg;
  assign done            = done_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed tiles against a word-level scoreboard of the tile
// (word k lives at base+4k and must appear k-th), plus literal pins.
module tb_weight_loader;
  import wl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        DW_PW_sel = 1'b0;
  logic [31:0] base_addr = '0;
  logic [5:0]  row_num = '0;
  logic [4:0]  col_in = '0;
  logic [5:0]  row_en;
  logic [4:0]  col_out;
  logic        DW_PW_sel_out, change_weight_f, busy, done;

  wl_if #(.ADDR_W(32)) bus ();

  weight_loader #(.ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .DW_PW_sel       (DW_PW_sel),
    .base_addr       (base_addr),
    .row_num         (row_num),
    .col_in          (col_in),
    .bus             (bus),
    .row_en          (row_en),
    .col_out         (col_out),
    .DW_PW_sel_out   (DW_PW_sel_out),
    .change_weight_f (change_weight_f),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rnd_ready = 1'b0;

  // scoreboard state for the current tile
  bit          m_active = 1'b0;
  logic [31:0] m_base = '0;
  int          m_total = 0, m_reads = 0, m_hs = 0;
  bit          seen_first = 1'b0, prev_stall = 1'b0, last_hs_prev = 1'b0;
  logic [31:0] prev_word = '0, first_word = '0, last_word = '0, last_addr = '0;
  int          start_cyc = 0, cwf_cyc = -1, re_cyc = -1, val_cyc = -1;
  int          done_cyc = -1, last_hs_cyc = -1, n_cwf = 0, n_re = 0, valid_cycles = 0;

  function automatic logic [31:0] glb_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // GLB model: one-cycle read latency
  always @(posedge clk) if (bus.glb_re) bus.glb_rdata <= glb_word(bus.glb_addr);

  // buffer-side ready pattern
  initial begin
    bus.ready_w = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.ready_w = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // per-cycle compare against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (change_weight_f) begin
          n_cwf++;
          if (cwf_cyc < 0) cwf_cyc = cyc;
          chk("cwf_excl_valid", 32'(bus.valid_w), 32'd0);
        end
        if (bus.glb_re) begin
          if (!m_active) begin
            chk("stray_read", 32'(bus.glb_re), 32'd0);
          end else begin
            if (re_cyc < 0) re_cyc = cyc;
            chk("glb_addr", bus.glb_addr, m_base + 32'(4 * m_reads));
            chk("read_budget", 32'(m_reads < m_total), 32'd1);
            m_reads++;
            n_re++;
            last_addr = bus.glb_addr;
          end
        end
        if (m_active) begin
          if (seen_first && m_hs < m_total) chk("valid_cont", 32'(bus.valid_w), 32'd1);
          if (prev_stall) chk("stall_hold", bus.weight_in, prev_word);
          if (m_total > 0) chk("done_timing", 32'(done), 32'(last_hs_prev));
          if (done && done_cyc < 0) done_cyc = cyc;
          last_hs_prev = 1'b0;
          if (bus.valid_w) begin
            valid_cycles++;
            if (val_cyc < 0) val_cyc = cyc;
            seen_first = 1'b1;
          end
          if (bus.valid_w && bus.ready_w) begin
            chk("word", bus.weight_in, glb_word(m_base + 32'(4 * m_hs)));
            if (m_hs == 0) first_word = bus.weight_in;
            last_word   = bus.weight_in;
            last_hs_cyc = cyc;
            m_hs++;
            if (m_hs == m_total) last_hs_prev = 1'b1;
          end
          prev_stall = bus.valid_w && !bus.ready_w;
          prev_word  = bus.weight_in;
        end else if (bus.valid_w) begin
          chk("stray_valid", 32'(bus.valid_w), 32'd0);
        end
      end
    end
  end

  task automatic begin_tile(input logic [31:0] base, input logic [5:0] rows, input logic [4:0] col,
                            input logic sel, input bit rnd, input int exp_total);
    @(posedge clk); #1;
    m_base = base; m_total = exp_total; m_reads = 0; m_hs = 0;
    seen_first = 0; prev_stall = 0; last_hs_prev = 0;
    cwf_cyc = -1; re_cyc = -1; val_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
    n_cwf = 0; n_re = 0; valid_cycles = 0;
    m_active = 1'b1;
    rnd_ready = rnd;
    base_addr = base; row_num = rows; col_in = col; DW_PW_sel = sel; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 32'hDEAD_BEE0; row_num = 6'd7; col_in = 5'd0; DW_PW_sel = ~sel;
  endtask

  task automatic finish_tile(input int budget, input int busy_at);
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      start = (i == busy_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    m_active = 1'b0;
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("hs_count", 32'(m_hs), 32'(m_total));
    chk("rd_count", 32'(m_reads), 32'(m_total));
    $display("tile base=0x%08h words=%0d handshakes=%0d reads=%0d done_at=+%0d",
             m_base, m_total, m_hs, m_reads, done_cyc - start_cyc);
    rnd_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_glb_re", 32'(bus.glb_re), 32'd0);
    chk("rst_glb_addr", bus.glb_addr, 32'd0);
    chk("rst_valid", 32'(bus.valid_w), 32'd0);
    chk("rst_weight", bus.weight_in, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cwf", 32'(change_weight_f), 32'd0);
    chk("rst_row_en", 32'(row_en), 32'd0);
    chk("rst_col_out", 32'(col_out), 32'd0);
`ifdef WL_DW_EN
    chk("rst_mode", 32'(DW_PW_sel_out), 32'd0);
`else
    chk("rst_mode", 32'(DW_PW_sel_out), 32'd1);
`endif

    // PW 4 rows x 8 words, full throughput
    begin_tile(32'h100, 6'd4, 5'd31, 1'b1, 1'b0, 32);
    finish_tile(200, -1);
    chk("lat_cwf", 32'(cwf_cyc - start_cyc), 32'd1);
    chk("lat_first_re", 32'(re_cyc - start_cyc), 32'd2);
    chk("lat_first_valid", 32'(val_cyc - start_cyc), 32'd4);
    chk("lat_done", 32'(done_cyc - last_hs_cyc), 32'd1);
    chk("valid_run", 32'(last_hs_cyc - val_cyc + 1), 32'd32);
    chk("valid_cycles", 32'(valid_cycles), 32'd32);
    chk("first_word", first_word, 32'hBFEF_0100);
    chk("last_word", last_word, 32'hBF93_017C);
    chk("last_addr", last_addr, 32'h0000_017C);
    chk("row_en_pw", 32'(row_en), 32'd4);
    chk("col_out_pw", 32'(col_out), 32'd31);
    chk("mode_pw", 32'(DW_PW_sel_out), 32'd1);

    // PW 32 rows x 1 word, random back-pressure, start pulsed mid-tile
    begin_tile(32'h400, 6'd32, 5'd3, 1'b1, 1'b1, 32);
    finish_tile(400, 10);
    chk("row_en_busy_start", 32'(row_en), 32'd32);
    chk("col_out_busy_start", 32'(col_out), 32'd3);

    // DW request (PW fallback when the DW feature is absent)
`ifdef WL_DW_EN
    begin_tile(32'hC00, 6'd30, 5'd31, 1'b0, 1'b0, 30);
    finish_tile(200, -1);
    chk("mode_dw", 32'(DW_PW_sel_out), 32'd0);
    chk("last_addr_dw", last_addr, 32'h0000_0C74);
`else
    begin_tile(32'hC00, 6'd30, 5'd7, 1'b0, 1'b0, 60);
    finish_tile(200, -1);
    chk("mode_dw_ignored", 32'(DW_PW_sel_out), 32'd1);
    chk("last_addr_dw_ignored", last_addr, 32'h0000_0CEC);
`endif
    chk("row_en_dw", 32'(row_en), 32'd30);

    // empty tile
    begin_tile(32'h800, 6'd0, 5'd31, 1'b1, 1'b0, 0);
    finish_tile(20, -1);
    chk("zero_done_lat", 32'(done_cyc - start_cyc), 32'd2);
    chk("zero_reads", 32'(n_re), 32'd0);
    chk("zero_cwf", 32'(n_cwf), 32'd0);
    chk("zero_row_en", 32'(row_en), 32'd0);

    // reset in the middle of a 256-word tile, then reload
    begin_tile(32'h2000, 6'd32, 5'd31, 1'b1, 1'b0, 256);
    begin
      int w = 0;
      while (m_hs < 10 && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      if (m_hs < 10) chk("hs10_timeout", 32'(m_hs), 32'd10);
    end
    reset = 1'b1;
    m_active = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.valid_w), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_row_en", 32'(row_en), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    begin_tile(32'h2000, 6'd2, 5'd31, 1'b1, 1'b0, 16);
    finish_tile(100, -1);
    chk("reload_first_word", first_word, 32'h9EEF_2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
